// File: rtl/branch_recovery_ctrl_pkg.sv
// Types and constants shared by the branch recovery controller and its slot selector.
package rv32i_types;

    localparam int SS_FACTOR             = 2;
    localparam int SS_FACTOR_BITS        = 1;
    localparam int NUM_BRANCH_BITS       = 3;
    localparam int NUM_ROB_ENTRIES_BITS  = 5;
    localparam int REFILL_CYCLES_DEFAULT = 2;

    typedef struct packed {
        logic [NUM_ROB_ENTRIES_BITS-1:0] rob_idx;
        logic [31:0]                     branch_pc;
    } brq_entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FLUSH  = 2'd1,
        REFILL = 2'd2
    } recov_state_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/branch_recovery_ctrl_slot_sel.sv
// Picks the lowest committing slot flagged as a mispredicted branch.
module mispredict_slot_sel
    import rv32i_types::*;
#(
    parameter int SS       = SS_FACTOR,
    parameter int SS_BITS  = SS_FACTOR_BITS,
    parameter int ROB_BITS = NUM_ROB_ENTRIES_BITS
) (
    input  logic [SS_BITS:0]   commit_cnt_i,
    input  logic [ROB_BITS-1:0] rob_head_idx_i,
    input  logic [SS-1:0]      commit_mispredict_i,
    output logic [SS-1:0]      br_queue_mask_o,
    output logic [ROB_BITS-1:0] mispredict_rob_idx_o,
    output logic               sel_valid_o
);

    always_comb begin
        br_queue_mask_o      = '0;
        mispredict_rob_idx_o = rob_head_idx_i;
        sel_valid_o          = 1'b0;
        // Walk high to low so the lowest qualifying slot is the last writer.
        for (int i = SS - 1; i >= 0; i--) begin
            if (((SS_BITS + 1)'(i) < commit_cnt_i) && commit_mispredict_i[i]) begin
                br_queue_mask_o      = '0;
                br_queue_mask_o[i]   = 1'b1;
                mispredict_rob_idx_o = rob_head_idx_i + ROB_BITS'(i);
                sel_valid_o          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Misprediction recovery sequencer (flush, redirect, refill stall) plus
// all-or-nothing branch-queue admission for the dispatch group.
module branch_recovery_ctrl
    import rv32i_types::*;
#(
    parameter int SS            = SS_FACTOR,
    parameter int SS_BITS       = SS_FACTOR_BITS,
    parameter int DEPTH_BITS    = NUM_BRANCH_BITS,
    parameter int ROB_BITS      = NUM_ROB_ENTRIES_BITS,
    parameter int REFILL_CYCLES = REFILL_CYCLES_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SS_BITS:0]    commit_cnt,
    input  logic [ROB_BITS-1:0] rob_head_idx,
    input  logic [SS-1:0]       commit_mispredict,
    input  brq_entry_t          brq_lookup,
    output logic [ROB_BITS-1:0] mispredict_rob_idx,
    output logic [SS-1:0]       br_queue_mask,
    input  logic [SS_BITS:0]    brq_req,
    input  logic [DEPTH_BITS:0] num_free_brq_entries,
    output logic [SS_BITS:0]    brq_push,
    output logic                dispatch_stall,
    output logic                mispredict,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    output logic                rec_err,
    output logic [31:0]         mispredict_count
);

    recov_state_t  state_q, state_d;
    logic [3:0]    refill_cnt_q, refill_cnt_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;
    logic          rec_err_q, rec_err_d;
    logic [31:0]   count_q, count_d;
    logic          sel_valid;
    logic          fits;
    logic [DEPTH_BITS:0] req_ext;

    mispredict_slot_sel #(
        .SS       (SS),
        .SS_BITS  (SS_BITS),
        .ROB_BITS (ROB_BITS)
    ) u_slot_sel (
        .commit_cnt_i         (commit_cnt),
        .rob_head_idx_i       (rob_head_idx),
        .commit_mispredict_i  (commit_mispredict),
        .br_queue_mask_o      (br_queue_mask),
        .mispredict_rob_idx_o (mispredict_rob_idx),
        .sel_valid_o          (sel_valid)
    );

    always_comb begin
        state_d       = state_q;
        refill_cnt_d  = refill_cnt_q;
        redirect_pc_d = redirect_pc_q;
        rec_err_d     = rec_err_q;
        count_d       = count_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d       = FLUSH;
                    redirect_pc_d = brq_lookup.branch_pc;
                    // A tag mismatch is flagged but the captured target is still used.
                    if (brq_lookup.rob_idx != mispredict_rob_idx) begin
                        rec_err_d = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d      = REFILL;
                refill_cnt_d = 4'(REFILL_CYCLES);
                count_d      = sat_inc32(count_q);
            end
            REFILL: begin
                if (refill_cnt_q <= 4'd1) begin
                    state_d = IDLE;
                end else begin
                    refill_cnt_d = refill_cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            refill_cnt_q  <= '0;
            redirect_pc_q <= '0;
            rec_err_q     <= 1'b0;
            count_q       <= '0;
        end else begin
            state_q       <= state_d;
            refill_cnt_q  <= refill_cnt_d;
            redirect_pc_q <= redirect_pc_d;
            rec_err_q     <= rec_err_d;
            count_q       <= count_d;
        end
    end

    assign req_ext = (DEPTH_BITS + 1)'(brq_req);
    assign fits    = (req_ext <= num_free_brq_entries);

    // Pushes granted in a detect cycle are later discarded by the flush.
    assign brq_push         = ((state_q == IDLE) && fits) ? brq_req : '0;
    assign dispatch_stall   = (state_q != IDLE) || !fits;
    assign mispredict       = (state_q == FLUSH);
    assign redirect_valid   = (state_q == FLUSH);
    assign redirect_pc      = redirect_pc_q;
    assign rec_err          = rec_err_q;
    assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Directed scoreboard bench: the driver queues expected recoveries, a monitor checks each flush.
module tb_branch_recovery_ctrl;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  commit_cnt;
    logic [4:0]  rob_head_idx;
    logic [1:0]  commit_mispredict;
    brq_entry_t  brq_lookup;
    logic [4:0]  mispredict_rob_idx;
    logic [1:0]  br_queue_mask;
    logic [1:0]  brq_req;
    logic [3:0]  num_free_brq_entries;
    logic [1:0]  brq_push;
    logic        dispatch_stall;
    logic        mispredict;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        rec_err;
    logic [31:0] mispredict_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
        int          stall;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    branch_recovery_ctrl #(
        .SS(2), .SS_BITS(1), .DEPTH_BITS(3), .ROB_BITS(5), .REFILL_CYCLES(2)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .commit_cnt           (commit_cnt),
        .rob_head_idx         (rob_head_idx),
        .commit_mispredict    (commit_mispredict),
        .brq_lookup           (brq_lookup),
        .mispredict_rob_idx   (mispredict_rob_idx),
        .br_queue_mask        (br_queue_mask),
        .brq_req              (brq_req),
        .num_free_brq_entries (num_free_brq_entries),
        .brq_push             (brq_push),
        .dispatch_stall       (dispatch_stall),
        .mispredict           (mispredict),
        .redirect_valid       (redirect_valid),
        .redirect_pc          (redirect_pc),
        .rec_err              (rec_err),
        .mispredict_count     (mispredict_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_commit(input logic [1:0] cnt, input logic [4:0] head, input logic [1:0] mp,
                                input logic [4:0] lidx, input logic [31:0] lpc);
        commit_cnt           = cnt;
        rob_head_idx         = head;
        commit_mispredict    = mp;
        brq_lookup.rob_idx   = lidx;
        brq_lookup.branch_pc = lpc;
    endtask

    task automatic clear_commit();
        commit_cnt        = '0;
        commit_mispredict = '0;
    endtask

    task automatic expect_flush(input logic [31:0] pc, input logic [31:0] cnt, input int stall);
        exp_t e;
        e.pc = pc; e.cnt = cnt; e.stall = stall;
        sb_q.push_back(e);
    endtask

    // Monitor: every flush pulse must match the next queued expectation.
    initial begin
        exp_t e;
        int   run;
        forever begin
            @(negedge clk);
            if (mispredict) begin
                if (sb_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_flush: got flush with pc 0x%08h want none", redirect_pc);
                end else begin
                    e = sb_q.pop_front();
                    chk("redirect_pc", redirect_pc, e.pc);
                    chk("redirect_valid", 32'(redirect_valid), 32'd1);
                    run = 1;
                    @(negedge clk);
                    chk("mispredict_count", mispredict_count, e.cnt);
                    while (dispatch_stall && run < 40) begin
                        run++;
                        @(negedge clk);
                    end
                    chk("stall_cycles", 32'(run), 32'(e.stall));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_commit();
        rob_head_idx = '0;
        brq_lookup   = '0;
        brq_req      = '0;
        num_free_brq_entries = 4'd4;
        repeat (2) @(negedge clk);
        chk("rst_mispredict", 32'(mispredict), 32'd0);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_stall", 32'(dispatch_stall), 32'd0);
        chk("rst_rec_err", 32'(rec_err), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_count", mispredict_count, 32'd0);
        rst = 1'b0;

        // Basic recovery: slot 1, head 5 -> ROB 6
        @(negedge clk);
        drive_commit(2'd2, 5'd5, 2'b10, 5'd6, 32'h8000_0040);
        #1;
        chk("basic_mask", 32'(br_queue_mask), 32'b10);
        chk("basic_idx", 32'(mispredict_rob_idx), 32'd6);
        expect_flush(32'h8000_0040, 32'd1, 3);
        @(negedge clk);
        clear_commit();
        repeat (5) @(negedge clk);
        chk("basic_rec_err", 32'(rec_err), 32'd0);

        // Priority: both slots mispredict, slot 0 wins; second pulse during REFILL ignored
        @(negedge clk);
        drive_commit(2'd2, 5'd10, 2'b11, 5'd10, 32'h0000_1000);
        #1;
        chk("prio_mask", 32'(br_queue_mask), 32'b01);
        chk("prio_idx", 32'(mispredict_rob_idx), 32'd10);
        expect_flush(32'h0000_1000, 32'd2, 3);
        @(negedge clk);
        clear_commit();
        @(negedge clk);
        drive_commit(2'd1, 5'd12, 2'b01, 5'd12, 32'hDEAD_0000);
        brq_req = 2'd2;
        #1;
        chk("refill_push", 32'(brq_push), 32'd0);
        @(negedge clk);
        clear_commit();
        brq_req = '0;
        repeat (5) @(negedge clk);
        chk("count_after_ignored", mispredict_count, 32'd2);

        // commit_cnt gating: slot 1 flagged but only one slot commits
        @(negedge clk);
        drive_commit(2'd1, 5'd14, 2'b10, 5'd15, 32'hBAD0_0000);
        #1;
        chk("gate_mask", 32'(br_queue_mask), 32'b00);
        @(negedge clk);
        clear_commit();
        repeat (4) @(negedge clk);
        chk("gate_count", mispredict_count, 32'd2);

        // ROB index wrap with a mismatching lookup tag
        @(negedge clk);
        drive_commit(2'd2, 5'd31, 2'b10, 5'd3, 32'h2222_0000);
        #1;
        chk("wrap_idx", 32'(mispredict_rob_idx), 32'd0);
        chk("wrap_mask", 32'(br_queue_mask), 32'b10);
        expect_flush(32'h2222_0000, 32'd3, 3);
        @(negedge clk);
        clear_commit();
        chk("rec_err_set", 32'(rec_err), 32'd1);
        repeat (6) @(negedge clk);
        chk("rec_err_sticky", 32'(rec_err), 32'd1);

        // Admission boundaries in IDLE
        brq_req = 2'd2; num_free_brq_entries = 4'd1;
        #1;
        chk("adm_a_push", 32'(brq_push), 32'd0);
        chk("adm_a_stall", 32'(dispatch_stall), 32'd1);
        brq_req = 2'd1;
        #1;
        chk("adm_b_push", 32'(brq_push), 32'd1);
        chk("adm_b_stall", 32'(dispatch_stall), 32'd0);
        brq_req = 2'd0; num_free_brq_entries = 4'd0;
        #1;
        chk("adm_zero_stall", 32'(dispatch_stall), 32'd0);
        num_free_brq_entries = 4'd4;

        // Reset during REFILL
        @(negedge clk);
        drive_commit(2'd2, 5'd0, 2'b01, 5'd0, 32'h0000_3000);
        expect_flush(32'h0000_3000, 32'd4, 2);
        @(negedge clk);
        clear_commit();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_mispredict", 32'(mispredict), 32'd0);
        chk("mid_rst_stall", 32'(dispatch_stall), 32'd0);
        chk("mid_rst_pc", redirect_pc, 32'd0);
        chk("mid_rst_count", mispredict_count, 32'd0);
        chk("mid_rst_rec_err", 32'(rec_err), 32'd0);
        rst = 1'b0;

        // Fresh recovery after reset
        @(negedge clk);
        drive_commit(2'd2, 5'd7, 2'b01, 5'd7, 32'h0000_4444);
        #1;
        chk("fresh_idx", 32'(mispredict_rob_idx), 32'd7);
        expect_flush(32'h0000_4444, 32'd1, 3);
        @(negedge clk);
        clear_commit();
        repeat (6) @(negedge clk);
        chk("fresh_rec_err", 32'(rec_err), 32'd0);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
